// File: rtl/maxpool_tuser_sequencer_if.sv
// Configuration, input AXIS and output AXIS signals of the maxpool tuser sequencer.
// The sequencer uses the slave view; whoever feeds it and drains it uses the master view.
interface maxpool_tuser_sequencer_if #(
  parameter int DATA_W       = 256,
  parameter int KW_W         = 2,
  parameter int COLS_WIDTH   = 10,
  parameter int BLOCKS_WIDTH = 10
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [KW_W-1:0]         cfg_kw;
  logic [COLS_WIDTH-1:0]   cfg_cols;
  logic [BLOCKS_WIDTH-1:0] cfg_blocks;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic [DATA_W-1:0]       s_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic [DATA_W-1:0]       m_axis_tdata;
  logic [2:0]              m_axis_tuser;
  logic                    m_axis_tlast;

  modport slave (
    input  cfg_valid, cfg_kw, cfg_cols, cfg_blocks, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output cfg_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );

  modport master (
    output cfg_valid, cfg_kw, cfg_cols, cfg_blocks, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  cfg_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/maxpool_tuser_sequencer.sv
// Per-layer controller ahead of the maxpool engine: registers the conv stream,
// stamps tuser (NOT_MAX/MAX/1X1) from k/c/b counters and marks the final beat with tlast.
//   state   | meaning
//   S_IDLE  | waiting for a layer config, input stalled
//   S_RUN   | passing beats, counting k/c/b
//   S_FLUSH | final beat taken, waiting for it to leave the output register
module maxpool_tuser_sequencer #(
  parameter int UNITS        = 8,
  parameter int GROUPS       = 2,
  parameter int WORD_WIDTH   = 8,
  parameter int KERNEL_W_MAX = 3,
  parameter int COLS_WIDTH   = 10,
  parameter int BLOCKS_WIDTH = 10,
  parameter int I_IS_NOT_MAX = 0,
  parameter int I_IS_MAX     = 1,
  parameter int I_IS_1X1     = 2
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  maxpool_tuser_sequencer_if.slave       bus,
  output logic                           cfg_err,
  output logic                           busy,
  output logic                           done
);
  localparam int KW_W   = $clog2(KERNEL_W_MAX + 1);
  localparam int DATA_W = GROUPS * UNITS * 2 * WORD_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                  state_q, state_d;
  logic                    alive_q;
  logic [KW_W-1:0]         kw_q, k_q;
  logic [COLS_WIDTH-1:0]   cols_q, c_q;
  logic [BLOCKS_WIDTH-1:0] blocks_q, b_q;
  logic                    mv_q, last_q, err_q, done_q;
  logic [DATA_W-1:0]       data_q;
  logic [2:0]              user_q, user_c;
  logic                    cfg_ready_c, s_ready_c, busy_c;
  logic                    cfg_hs, cfg_bad, s_hs, m_hs;
  logic                    k_wrap, c_wrap, b_wrap, beat_last;
  logic [KW_W:0]           kw_ext;

  assign kw_ext    = {1'b0, bus.cfg_kw};
  assign cfg_hs    = bus.cfg_valid && cfg_ready_c;
  assign cfg_bad   = (bus.cfg_kw == '0) || (kw_ext > (KW_W+1)'(KERNEL_W_MAX)) ||
                     (bus.cfg_cols == '0) || (bus.cfg_blocks == '0);
  assign s_hs      = bus.s_axis_tvalid && s_ready_c;
  assign m_hs      = mv_q && bus.m_axis_tready;
  assign k_wrap    = (k_q == kw_q - KW_W'(1));
  assign c_wrap    = (c_q == cols_q - COLS_WIDTH'(1));
  assign b_wrap    = (b_q == blocks_q - BLOCKS_WIDTH'(1));
  assign beat_last = k_wrap && c_wrap && b_wrap;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_hs && !cfg_bad) state_d = S_RUN;
      S_RUN:   if (s_hs && beat_last) state_d = S_FLUSH;
      S_FLUSH: if (m_hs && last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // alive_q keeps cfg_ready low while reset is held so every output reads 0
  always_comb begin
    cfg_ready_c = 1'b0;
    s_ready_c   = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      S_IDLE:  cfg_ready_c = alive_q;
      S_RUN: begin
        busy_c    = 1'b1;
        s_ready_c = !mv_q || bus.m_axis_tready;
      end
      S_FLUSH: busy_c = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    user_c               = '0;
    user_c[I_IS_1X1]     = (kw_q == KW_W'(1));
    user_c[I_IS_MAX]     = k_wrap;
    user_c[I_IS_NOT_MAX] = !k_wrap;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      kw_q     <= '0;
      cols_q   <= '0;
      blocks_q <= '0;
      k_q      <= '0;
      c_q      <= '0;
      b_q      <= '0;
    end else if (cfg_hs && !cfg_bad) begin
      kw_q     <= bus.cfg_kw;
      cols_q   <= bus.cfg_cols;
      blocks_q <= bus.cfg_blocks;
      k_q      <= '0;
      c_q      <= '0;
      b_q      <= '0;
    end else if (s_hs) begin
      k_q <= k_wrap ? '0 : k_q + KW_W'(1);
      if (k_wrap) c_q <= c_wrap ? '0 : c_q + COLS_WIDTH'(1);
      if (k_wrap && c_wrap) b_q <= b_wrap ? '0 : b_q + BLOCKS_WIDTH'(1);
    end
  end

  // a load while draining simply overwrites, so back-to-back beats leave no bubble
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mv_q   <= 1'b0;
      data_q <= '0;
      user_q <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (s_hs) begin
        mv_q   <= 1'b1;
        data_q <= bus.s_axis_tdata;
        user_q <= user_c;
        last_q <= beat_last;
      end else if (m_hs) begin
        mv_q   <= 1'b0;
        user_q <= '0;
        last_q <= 1'b0;
      end
      err_q  <= cfg_hs && cfg_bad;
      done_q <= (state_q == S_FLUSH) && m_hs && last_q;
    end
  end

  assign bus.cfg_ready     = cfg_ready_c;
  assign bus.s_axis_tready = s_ready_c;
  assign bus.m_axis_tvalid = mv_q;
  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tuser  = user_q;
  assign bus.m_axis_tlast  = last_q;
  assign cfg_err           = err_q;
  assign busy              = busy_c;
  assign done              = done_q;
endmodule
